// File: rtl/montgomery_unrolled_pkg.sv
// Shared RSA definitions for the Montgomery multiplier slice.
//   RSA_KEY_WIDTH       : default modulus/operand width in bits.
//   RSA_STEPS_PER_CYCLE : default number of radix-2 steps per clock.
//   mont_state_e        : controller states of montgomery_unrolled.
package montgomery_unrolled_pkg;

  localparam int unsigned RSA_KEY_WIDTH       = 256;
  localparam int unsigned RSA_STEPS_PER_CYCLE = 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mont_state_e;

endpackage

// File: rtl/montgomery_step.sv
// One combinational radix-2 Montgomery step:
//   r' = (r + a_bit*b + q*n) / 2, where q makes the numerator even.
// Ports:
//   i_r     : accumulator in (WIDTH bits)
//   i_b     : multiplicand B (WIDTH bits)
//   i_n     : modulus N (WIDTH bits)
//   i_a_bit : current multiplier bit of A
//   o_r     : accumulator out (WIDTH bits)
module montgomery_step #(
  parameter int unsigned WIDTH = 258
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  input  logic             i_a_bit,
  output logic [WIDTH-1:0] o_r
);

  // Two guard bits so the partial sums never wrap, even for
  // out-of-range operands.
  logic [WIDTH+1:0] sum_ab;
  logic [WIDTH+1:0] sum_abn;

  always_comb begin
    sum_ab  = (WIDTH+2)'(i_r) + (i_a_bit ? (WIDTH+2)'(i_b) : '0);
    sum_abn = sum_ab + (sum_ab[0] ? (WIDTH+2)'(i_n) : '0);
    o_r     = WIDTH'(sum_abn >> 1);
  end

endmodule

// File: rtl/montgomery_unrolled.sv
// Iterative Montgomery multiplier: o_out = A*B*2^-MOD_WIDTH mod N.
// STEPS_PER_CYCLE radix-2 steps are chained combinationally each clock,
// so a product takes MOD_WIDTH/STEPS_PER_CYCLE cycles after acceptance.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_valid / i_ready   : operand handshake (i_a, i_b, i_modulus)
//   o_valid / o_ready   : result handshake (o_out held while waiting)
module montgomery_unrolled
  import montgomery_unrolled_pkg::*;
#(
  parameter int unsigned MOD_WIDTH       = RSA_KEY_WIDTH,
  parameter int unsigned STEPS_PER_CYCLE = RSA_STEPS_PER_CYCLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_a,
  input  logic [MOD_WIDTH-1:0] i_b,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out
);

  localparam int unsigned EXT_W = MOD_WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(MOD_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(STEPS_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MOD_WIDTH - STEPS_PER_CYCLE);

  mont_state_e          state_q, state_d;
  logic [EXT_W-1:0]     a_q, a_d;
  logic [EXT_W-1:0]     b_q, b_d;
  logic [EXT_W-1:0]     n_q, n_d;
  logic [EXT_W-1:0]     r_q, r_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MOD_WIDTH-1:0] out_q, out_d;

  logic [EXT_W-1:0] r_chain [STEPS_PER_CYCLE+1];
  logic [EXT_W-1:0] r_final;

  assign r_chain[0] = r_q;

  // A is shifted right every cycle, so step j always consumes bit j.
  for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
    montgomery_step #(
      .WIDTH(EXT_W)
    ) u_step (
      .i_r    (r_chain[j]),
      .i_b    (b_q),
      .i_n    (n_q),
      .i_a_bit(a_q[j]),
      .o_r    (r_chain[j+1])
    );
  end

  assign r_final = r_chain[STEPS_PER_CYCLE];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = EXT_W'(i_a);
          b_d     = EXT_W'(i_b);
          n_d     = EXT_W'(i_modulus);
          r_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_q >> STEPS_PER_CYCLE;
        r_d   = r_final;
        cnt_d = cnt_q + CNT_STEP;
        // Counter-driven exit: terminates regardless of operand values.
        if (cnt_q >= LAST_CNT) begin
          out_d   = MOD_WIDTH'((r_final >= n_q) ? (r_final - n_q) : r_final);
          state_d = DONE;
        end
      end
      DONE: begin
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_out   = out_q;

endmodule

// File: tb/tb_montgomery_unrolled.sv
// Scoreboard bench: a small 8-bit instance for directed/boundary cases and
// four 256-bit instances (1,2,4,8 steps per cycle) fed identical random
// operands. Expected results come from a REDC-formula reference model.
module tb_montgomery_unrolled;

  localparam int unsigned NL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] val;
    int unsigned  acc;
  } exp_t;

  exp_t q_s[$];
  exp_t q_l[NL][$];

  // small instance
  logic       s_i_valid, s_i_ready, s_o_valid, s_o_ready;
  logic [7:0] s_a, s_b, s_n, s_out;

  // large instances
  logic         l_i_valid;
  logic [255:0] l_a, l_b, l_n;
  logic         l_i_ready [NL];
  logic         l_o_valid [NL];
  logic [255:0] l_out     [NL];
  logic         l_o_ready = 1'b1;

  montgomery_unrolled #(
    .MOD_WIDTH      (8),
    .STEPS_PER_CYCLE(2)
  ) u_dut_s (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (s_i_valid),
    .i_ready  (s_i_ready),
    .i_a      (s_a),
    .i_b      (s_b),
    .i_modulus(s_n),
    .o_valid  (s_o_valid),
    .o_ready  (s_o_ready),
    .o_out    (s_out)
  );

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  // Reference: Montgomery reduction via REDC, T = (ab + m*n) / 2^w with
  // m = -ab * n^-1 mod 2^w, then one conditional subtraction.
  function automatic logic [255:0] mont_ref(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] n, input int unsigned w);
    logic [255:0] inv, mask, m;
    logic [767:0] ab, t;
    inv = n;
    for (int i = 0; i < 8; i++) inv = inv * (256'd2 - n * inv);
    mask = (w >= 256) ? '1 : ((256'd1 << w) - 256'd1);
    ab   = 768'(a) * 768'(b);
    m    = ((256'd0 - ab[255:0]) * inv) & mask;
    t    = (ab + 768'(m) * 768'(n)) >> w;
    if (t >= 768'(n)) t = t - 768'(n);
    return t[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_big
    montgomery_unrolled #(
      .MOD_WIDTH      (256),
      .STEPS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (l_i_valid),
      .i_ready  (l_i_ready[g]),
      .i_a      (l_a),
      .i_b      (l_b),
      .i_modulus(l_n),
      .o_valid  (l_o_valid[g]),
      .o_ready  (l_o_ready),
      .o_out    (l_out[g])
    );

    initial begin : mon_big
      exp_t e;
      forever begin
        @(posedge clk);
        #1;
        if (!rst && l_o_valid[g]) begin
          if (q_l[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL big_s%0d_unexpected got=%0h", 1 << g, l_out[g]);
          end else begin
            e = q_l[g].pop_front();
            chk($sformatf("big_s%0d_result", 1 << g), l_out[g], e.val);
            chk($sformatf("big_s%0d_latency", 1 << g), 256'(cyc - e.acc), 256'(256 >> g));
          end
        end
      end
    end
  end

  // Small-instance monitor; owns s_o_ready so it can stall the result.
  int unsigned hold_req  = 0;
  int unsigned hold_left = 0;

  initial begin : mon_small
    exp_t       e;
    logic [7:0] held;
    bit         prev;
    prev      = 1'b0;
    held      = '0;
    s_o_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev      = 1'b0;
        hold_left = 0;
        s_o_ready = 1'b1;
      end else if (s_o_valid && !prev) begin
        prev = 1'b1;
        held = s_out;
        if (q_s.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL small_unexpected got=%0h", s_out);
        end else begin
          e = q_s.pop_front();
          chk("small_result", 256'(s_out), e.val);
          chk("small_latency", 256'(cyc - e.acc), 256'(4));
        end
        if (hold_req > 0) begin
          s_o_ready = 1'b0;
          hold_left = hold_req;
          hold_req  = 0;
        end
      end else if (s_o_valid && prev) begin
        if (hold_left > 0) begin
          chk("hold_out_stable", 256'(s_out), 256'(held));
          chk("hold_i_ready", 256'(s_i_ready), 256'(0));
          hold_left--;
          if (hold_left == 0) s_o_ready = 1'b1;
        end else begin
          checks++;
          errors++;
          $display("FAIL small_valid_drop got=1 exp=0");
        end
      end else begin
        if (prev && hold_left > 0) begin
          checks++;
          errors++;
          $display("FAIL hold_valid got=0 exp=1");
          hold_left = 0;
          s_o_ready = 1'b1;
        end
        prev = 1'b0;
      end
    end
  end

  task automatic send_s(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                        input bit push, input logic [255:0] expv);
    int unsigned t = 0;
    while (!s_i_ready && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!s_i_ready) begin
      checks++;
      errors++;
      $display("FAIL send_s_timeout got=0 exp=1");
      return;
    end
    s_a = a;
    s_b = b;
    s_n = n;
    s_i_valid = 1'b1;
    if (push) q_s.push_back('{expv, cyc + 1});
    @(posedge clk);
    #1;
    s_i_valid = 1'b0;
  endtask

  task automatic wait_s();
    int unsigned t = 0;
    while ((q_s.size() != 0 || !s_i_ready) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q_s.size() != 0 || !s_i_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_s_timeout pending=%0d", q_s.size());
    end
  endtask

  function automatic bit all_l_ready();
    bit r = 1'b1;
    for (int g = 0; g < NL; g++) r = r & l_i_ready[g];
    return r;
  endfunction

  function automatic int l_pending();
    int p = 0;
    for (int g = 0; g < NL; g++) p += q_l[g].size();
    return p;
  endfunction

  task automatic send_l(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n);
    int unsigned  t = 0;
    logic [255:0] expv;
    while (!all_l_ready() && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!all_l_ready()) begin
      checks++;
      errors++;
      $display("FAIL send_l_timeout got=0 exp=1");
      return;
    end
    expv = mont_ref(a, b, n, 256);
    l_a = a;
    l_b = b;
    l_n = n;
    l_i_valid = 1'b1;
    for (int g = 0; g < NL; g++) q_l[g].push_back('{expv, cyc + 1});
    @(posedge clk);
    #1;
    l_i_valid = 1'b0;
    t = 0;
    while (l_pending() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (l_pending() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_l_timeout pending=%0d", l_pending());
    end
  endtask

  initial begin : watchdog
    #900000;
    errors++;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : driver
    logic [7:0]   n8, a8, b8;
    logic [255:0] n, a, b, p, q;
    rst = 1'b1;
    s_i_valid = 1'b0;
    s_a = '0; s_b = '0; s_n = '0;
    l_i_valid = 1'b0;
    l_a = '0; l_b = '0; l_n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_valid", 256'(s_o_valid), 256'(0));
    chk("reset_o_out", 256'(s_out), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_i_ready", 256'(s_i_ready), 256'(1));
    chk("reset_big_i_ready", 256'(all_l_ready()), 256'(1));

    // directed small cases, expected values from hand-worked arithmetic
    send_s(8'd5, 8'd7, 8'd13, 1'b1, 256'd1);   wait_s();
    send_s(8'd12, 8'd12, 8'd13, 1'b1, 256'd3); wait_s();
    send_s(8'd1, 8'd1, 8'd13, 1'b1, 256'd3);   wait_s();
    send_s(8'd0, 8'd9, 8'd13, 1'b1, 256'd0);   wait_s();
    // 3*5 == 15 drives the final accumulator to exactly N
    send_s(8'd3, 8'd5, 8'd15, 1'b1, 256'd0);   wait_s();
    send_s(8'd254, 8'd254, 8'd255, 1'b1, mont_ref(256'd254, 256'd254, 256'd255, 8)); wait_s();

    // stall the result and poke i_valid while DONE
    hold_req = 10;
    send_s(8'd5, 8'd7, 8'd13, 1'b1, 256'd1);
    for (int t = 0; t < 200 && !s_o_valid; t++) begin
      @(posedge clk);
      #1;
    end
    s_a = 8'd2; s_b = 8'd3; s_n = 8'd13;
    s_i_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("done_i_ready", 256'(s_i_ready), 256'(0));
    end
    s_i_valid = 1'b0;
    wait_s();

    // abort mid-calculation
    send_s(8'd5, 8'd7, 8'd13, 1'b0, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_o_valid", 256'(s_o_valid), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_i_ready", 256'(s_i_ready), 256'(1));
    repeat (8) @(posedge clk);
    #1;
    send_s(8'd5, 8'd7, 8'd13, 1'b1, 256'd1);   wait_s();

    // random small sweep
    for (int i = 0; i < 30; i++) begin
      n8 = 8'($urandom_range(3, 255)) | 8'd1;
      a8 = 8'($urandom_range(0, int'(n8) - 1));
      b8 = 8'($urandom_range(0, int'(n8) - 1));
      send_s(a8, b8, n8, 1'b1, mont_ref(256'(a8), 256'(b8), 256'(n8), 8));
      wait_s();
    end

    // random 256-bit sweep across all step counts
    for (int i = 0; i < 20; i++) begin
      n = rand256() | 256'd1;
      if (i % 2 == 0) n[255] = 1'b1;
      if (n < 256'd3) n = 256'd3;
      a = rand256() % n;
      b = rand256() % n;
      send_l(a, b, n);
    end

    // N = p*q with A = p, B = q forces the final accumulator to equal N
    for (int i = 0; i < 4; i++) begin
      p = 256'(rand256() >> 128) | 256'd3;
      q = 256'(rand256() >> 128) | 256'd3;
      n = p * q;
      send_l(p, q, n);
    end

    chk("small_queue_empty", 256'(q_s.size()), 256'(0));
    chk("big_queue_empty", 256'(l_pending()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/montgomery_unrolled.md
MONTGOMERY_UNROLLED -- requirements
Module: montgomery_unrolled

Interface
REQ-001 The block SHALL have parameter MOD_WIDTH, default 256: width of modulus, operands and result.
REQ-002 The block SHALL have parameter STEPS_PER_CYCLE, default 2: radix-2 Montgomery steps executed per clock; legal values divide MOD_WIDTH.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operand set offered.
- i_ready  output  1  block can accept operands.
- i_a  input  MOD_WIDTH  multiplier A, A < N.
- i_b  input  MOD_WIDTH  multiplicand B, B < N.
- i_modulus  input  MOD_WIDTH  odd modulus N.
- o_valid  output  1  result available.
- o_ready  input  1  consumer accepts result.
- o_out  output  MOD_WIDTH  A*B*2^-MOD_WIDTH mod N.

Function
REQ-004 The block SHALL implement states IDLE, CALC and DONE.
REQ-005 In IDLE, i_ready SHALL be 1; o_valid SHALL be 0.
REQ-006 On i_valid && i_ready, the block SHALL capture A, B and N zero-extended to MOD_WIDTH+2 bits, clear the accumulator R and step counter, and move to CALC.
REQ-007 In CALC, each cycle SHALL apply STEPS_PER_CYCLE chained steps; step i: R += A[i] ? B : 0; if R odd, R += N; R >>= 1.
REQ-008 The step counter SHALL advance by STEPS_PER_CYCLE per CALC cycle; the last step index is MOD_WIDTH-1.
REQ-009 After the cycle completing step MOD_WIDTH-1, the block SHALL move to DONE.
REQ-010 On entry to DONE, o_out SHALL be registered as R-N if R >= N, else R; equality SHALL subtract, giving 0 when R == N.
REQ-011 Latency from the accept edge to o_valid SHALL be exactly MOD_WIDTH/STEPS_PER_CYCLE cycles.
REQ-012 In CALC, i_ready and o_valid SHALL both be 0; i_valid SHALL be ignored.
REQ-013 In DONE, o_valid SHALL be 1 and o_out SHALL hold stable until o_valid && o_ready.
REQ-014 On o_valid && o_ready, the block SHALL return to IDLE.
REQ-015 i_ready SHALL be 0 in DONE; there is no same-cycle output/input overlap.
REQ-016 Intermediate R SHALL never exceed MOD_WIDTH+2 bits for A,B < N; behaviour for A or B >= N, or even N, is unspecified but SHALL NOT hang the state machine.

Reset
REQ-017 While rst = 1, the block SHALL enter IDLE, with i_ready = 1 after reset deasserts, o_valid = 0, o_out = 0, R = 0 and counter = 0.
REQ-018 rst asserted in CALC or DONE SHALL abort the operation and drop o_valid on the next edge, discarding the result.

Structure
REQ-019 The shared RSA package SHALL hold the default key width constant and the step count default; extended width MOD_WIDTH+2 is derived locally.
REQ-020 One radix-2 step SHALL be a combinational sub-module montgomery_step (params WIDTH), instantiated STEPS_PER_CYCLE times in a chain.
REQ-021 Counter width SHALL be $clog2(MOD_WIDTH+1).

Verification
REQ-022 With MOD_WIDTH=8, STEPS_PER_CYCLE=2, N=13, A=5, B=7 -> o_valid 4 cycles after accept, o_out=1.
REQ-023 With N=13, A=12, B=12 -> o_out=3; A=1, B=1 -> o_out=3; A=0, B=9 -> o_out=0.
REQ-024 Hold o_ready=0 for 10 cycles in DONE -> o_valid stays 1, o_out is stable, i_ready=0, and extra i_valid pulses are ignored.
REQ-025 Assert rst mid-CALC -> next edge o_valid=0 and i_ready=1 once released; a new operation N=13, A=5, B=7 then yields 1.
REQ-026 Run a random sweep at MOD_WIDTH=256 with STEPS_PER_CYCLE in {1,2,4,8} against a golden model, including forced R==N cases -> all results match, with latency 256/STEPS_PER_CYCLE.
